// File: rtl/vector_pkg.sv
// ----------------------------------------------------------------------------
// vector_pkg
//   Shared definitions for the vector serializer.
//   VEC_N / VEC_W : default vector length and element width.
//   elem_t        : one vector element.
//   ser_state_e   : serializer FSM states (IDLE waits for a vector, SEND
//                   streams the captured elements out one per transfer).
// ----------------------------------------------------------------------------
package vector_pkg;

    localparam int VEC_N = 16;
    localparam int VEC_W = 32;

    typedef logic [VEC_W-1:0] elem_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/vector_serializer.sv
// ----------------------------------------------------------------------------
// vector_serializer
//   Captures an N-element parallel vector in one handshake and emits the
//   elements one at a time, lowest index first, on a valid/ready stream.
//
//   Optional feature (macro VECTOR_SERIALIZER_SUM_EN):
//     adds out_sum / out_sum_valid, a modulo-2^W checksum of the N
//     transferred elements, pulsed the cycle after the last transfer.
//
//   Parameters
//     N  : number of elements per vector (N >= 1)
//     W  : element width in bits
//
//   Ports
//     clk           in   single clock, rising edge
//     rst           in   synchronous active-high reset
//     in_valid      in   parallel vector offered on in_vec
//     in_ready      out  vector accepted this cycle (high only in IDLE)
//     in_vec        in   N x W parallel vector
//     out_valid     out  out_data holds a valid element
//     out_ready     in   downstream accepts the element
//     out_data      out  current element (0 when idle)
//     out_idx       out  index of the current element
//     out_last      out  current element is index N-1
//     out_sum       out  (SUM_EN only) checksum of the last vector
//     out_sum_valid out  (SUM_EN only) one-cycle checksum strobe
// ----------------------------------------------------------------------------
module vector_serializer
    import vector_pkg::*;
#(
    parameter  int N  = VEC_N,
    parameter  int W  = VEC_W,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_vec [N],
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [IW-1:0] out_idx,
    output logic          out_last
`ifdef VECTOR_SERIALIZER_SUM_EN
    ,
    output logic [W-1:0]  out_sum,
    output logic          out_sum_valid
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ser_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  vec_q [N];

    logic          capture;
    logic          xfer;
    logic          at_last;

    // A vector is only taken while idle; in SEND the input side is
    // completely ignored so in_vec is never re-sampled mid-stream.
    assign capture = (state_q == IDLE) && in_valid;
    assign xfer    = (state_q == SEND) && out_ready;
    assign at_last = (state_q == SEND) && (idx_q == IW'(N - 1));

    // ------------------------------------------------------------------
    // Next-state logic: FSM and element index
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (at_last) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Vector storage needs no reset: it is only observable in SEND, and
    // SEND can only be entered through a capture that overwrites it.
    always_ff @(posedge clk) begin
        if (capture && !rst) begin
            vec_q <= in_vec;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only, so there is no
    // combinational path from any in_* port to any out_* port.
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SEND);
    // Forced to zero when idle so reset/idle output value is well defined.
    assign out_data  = (state_q == SEND) ? vec_q[idx_q] : '0;
    // idx_q is held at 0 whenever the FSM is idle.
    assign out_idx   = idx_q;
    assign out_last  = at_last;

`ifdef VECTOR_SERIALIZER_SUM_EN
    // ------------------------------------------------------------------
    // Checksum: accumulate each transferred element; the strobe fires the
    // cycle after the final transfer, when sum_q already holds all N.
    // ------------------------------------------------------------------
    logic [W-1:0] sum_q, sum_d;
    logic         sum_vld_q, sum_vld_d;

    always_comb begin
        sum_d     = sum_q;
        sum_vld_d = xfer && at_last;
        if (capture) begin
            sum_d = '0;
        end else if (xfer) begin
            sum_d = sum_q + vec_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
        end
    end

    assign out_sum       = sum_q;
    assign out_sum_valid = sum_vld_q;
`endif

endmodule

// File: tb/tb_vector_serializer.sv
// ----------------------------------------------------------------------------
// tb_vector_serializer
//   Scoreboard bench. When a vector is accepted the reference model pushes
//   the N expected elements into a queue; at every falling edge the monitor
//   compares the presented element against the queue head and pops it on a
//   transfer. A second N=1 instance has its own small model.
// ----------------------------------------------------------------------------
module tb_vector_serializer;

    localparam int N = 16;
    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          in_valid, in_ready;
    logic [W-1:0]  in_vec [N];
    logic          out_valid, out_ready;
    logic [W-1:0]  out_data;
    logic [3:0]    out_idx;
    logic          out_last;
`ifdef VECTOR_SERIALIZER_SUM_EN
    logic [W-1:0]  out_sum;
    logic          out_sum_valid;
`endif

    logic          in_valid1, in_ready1;
    logic [W-1:0]  in_vec1 [1];
    logic          out_valid1, out_ready1;
    logic [W-1:0]  out_data1;
    logic [0:0]    out_idx1;
    logic          out_last1;
`ifdef VECTOR_SERIALIZER_SUM_EN
    logic [W-1:0]  out_sum1;
    logic          out_sum_valid1;
`endif

    vector_serializer #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last)
`ifdef VECTOR_SERIALIZER_SUM_EN
        , .out_sum(out_sum), .out_sum_valid(out_sum_valid)
`endif
    );

    vector_serializer #(.N(1), .W(W)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_vec(in_vec1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_idx(out_idx1), .out_last(out_last1)
`ifdef VECTOR_SERIALIZER_SUM_EN
        , .out_sum(out_sum1), .out_sum_valid(out_sum_valid1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model + monitor, N=16 instance
    // ------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] d;
        int           idx;
        bit           last;
    } item_t;

    item_t        q[$];
    logic [W-1:0] sum_acc;
    logic [W-1:0] sum_exp;
    bit           sum_pend;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            sum_acc  = '0;
            sum_pend = 1'b0;
        end else begin
            chk("in_ready",  {63'd0, in_ready},  {63'd0, q.size() == 0});
            chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
`ifdef VECTOR_SERIALIZER_SUM_EN
            chk("sum_valid", {63'd0, out_sum_valid}, {63'd0, sum_pend});
            if (sum_pend) chk("out_sum", 64'(out_sum), 64'(sum_exp));
`endif
            sum_pend = 1'b0;
            if (q.size() == 0) begin
                chk("idle_data", 64'(out_data), 64'd0);
                chk("idle_idx",  64'(out_idx),  64'd0);
                chk("idle_last", {63'd0, out_last}, 64'd0);
                if (in_valid) begin
                    sum_acc = '0;
                    for (int i = 0; i < N; i++) begin
                        item_t it;
                        it.d    = in_vec[i];
                        it.idx  = i;
                        it.last = (i == N - 1);
                        q.push_back(it);
                    end
                end
            end else begin
                chk("out_data", 64'(out_data), 64'(q[0].d));
                chk("out_idx",  64'(out_idx),  64'(q[0].idx));
                chk("out_last", {63'd0, out_last}, {63'd0, q[0].last});
                if (out_ready) begin
                    sum_acc = sum_acc + q[0].d;
                    if (q[0].last) begin
                        sum_pend = 1'b1;
                        sum_exp  = sum_acc;
                    end
                    void'(q.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model + monitor, N=1 instance
    // ------------------------------------------------------------------
    logic [W-1:0] q1[$];

    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
        end else begin
            chk("n1_in_ready",  {63'd0, in_ready1},  {63'd0, q1.size() == 0});
            chk("n1_out_valid", {63'd0, out_valid1}, {63'd0, q1.size() != 0});
            chk("n1_idx", 64'(out_idx1), 64'd0);
            if (q1.size() == 0) begin
                chk("n1_idle_last", {63'd0, out_last1}, 64'd0);
                if (in_valid1) q1.push_back(in_vec1[0]);
            end else begin
                chk("n1_data", 64'(out_data1), 64'(q1[0]));
                chk("n1_last", {63'd0, out_last1}, 64'd1);
                if (out_ready1) void'(q1.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: timeout, in_ready stuck at %0b", in_ready);
        end
    endtask

    task automatic wait_idx(input int k);
        int n = 0;
        while (!(out_valid && out_idx == 4'(k)) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idx: timeout waiting for idx %0d, saw %0d", k, out_idx);
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        in_vec1[0] = '0;
        for (int i = 0; i < N; i++) in_vec[i] = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Basic load: elements 0..15 back to back
        for (int i = 0; i < N; i++) in_vec[i] = W'(i);
        load();
        wait_idle();
        step();

        // Backpressure: stall 3 cycles on idx 5
        load();
        wait_idx(5);
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        wait_idle();
        step();

        // Input offered during SEND must be ignored
        for (int i = 0; i < N; i++) in_vec[i] = $urandom;
        load();
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) in_vec[i] = $urandom;
            step();
        end
        in_valid = 1'b0;
        wait_idle();
        step();

        // Reset mid-stream at idx 7, then a fresh vector 100..115
        for (int i = 0; i < N; i++) in_vec[i] = W'(i);
        load();
        wait_idx(7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < N; i++) in_vec[i] = W'(100 + i);
        load();
        wait_idle();
        step();

        // Checksum vector: i + (16 - i) = 16 per element, total 256
        for (int i = 0; i < N; i++) in_vec[i] = W'(i + (16 - i));
        load();
        wait_idle();
        repeat (2) step();

        // N=1: single element, then again with a short stall
        in_vec1[0] = 32'hDEADBEEF;
        in_valid1  = 1'b1;
        step();
        in_valid1  = 1'b0;
        repeat (3) step();
        in_vec1[0] = 32'h0BADF00D;
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        step();
        in_valid1  = 1'b0;
        repeat (2) step();
        out_ready1 = 1'b1;
        repeat (3) step();

        // Randomized traffic on both instances with occasional resets
        for (int c = 0; c < 1500; c++) begin
            out_ready  = ($urandom_range(0, 3) != 0);
            in_valid   = $urandom_range(0, 1);
            out_ready1 = $urandom_range(0, 1);
            in_valid1  = $urandom_range(0, 1);
            in_vec1[0] = $urandom;
            for (int i = 0; i < N; i++) in_vec[i] = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_valid1  = 1'b0;
        out_ready  = 1'b1;
        out_ready1 = 1'b1;
        wait_idle();
        repeat (3) step();
        chk("drain",  64'(q.size()),  64'd0);
        chk("drain1", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
